// File: rtl/storage_bus_arbiter.sv
// storage_bus_arbiter
// Shares the single-port matrix storage between three requesters (0: input
// subsystem, 1: calculator core, 2: display subsystem). Grants are registered
// and one-hot, rotate round-robin, and an unlocked owner is preempted after
// MAX_HOLD contended cycles. Reads are tagged with a per-port rvalid pulse
// that appears RD_LAT cycles after the access.
module storage_bus_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 16,
   parameter int RD_LAT   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          req,
   input  logic [2:0]          lock,
   input  logic [2:0]          m_we,
   input  logic [3*ADDR_W-1:0] m_addr,
   input  logic [3*DATA_W-1:0] m_wdata,
   output logic [2:0]          gnt,
   output logic [2:0]          rvalid,
   output logic [ADDR_W-1:0]   s_addr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic                s_we,
   output logic                busy
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_REL = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic {IDLE, OWN} state_t;

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [1:0]        rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [RD_LAT-1:0] rd_pipe_q [3];
   logic [RD_LAT-1:0] rd_pipe_d [3];

   logic [2:0] others;
   logic [2:0] cand;
   logic [1:0] win;
   logic       rel;
   logic [2:0] rd_acc;

   // Round-robin search: first candidate at or after ptr, wrapping modulo 3.
   // Caller must check that cand is non-zero before using the result.
   function automatic logic [1:0] rr_pick(input logic [2:0] cand_i, input logic [1:0] ptr);
      logic [1:0] idx;
      int         p;
      idx = 2'd0;
      for (int n = 2; n >= 0; n--) begin
         p = (int'(ptr) + n) % 3;
         if (cand_i[p]) idx = 2'(p);
      end
      return idx;
   endfunction

   // Arbitration: grant, release and preemption decisions for the next cycle.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      hold_cnt_d = hold_cnt_q;
      rel        = 1'b0;
      others     = req & ~gnt_q;
      cand       = (state_q == OWN) ? others : req;
      win        = rr_pick(cand, rr_ptr_q);

      case (state_q)
         IDLE: begin
            rel = |req;
         end
         OWN: begin
            // ">=" lets an owner whose counter saturated under lock yield as
            // soon as it drops lock while someone is waiting.
            rel = ~req[owner_q] |
                  (~lock[owner_q] & (|others) & (hold_cnt_q >= HOLD_REL));
            if (!rel && (|others) && (hold_cnt_q != HOLD_SAT))
               hold_cnt_d = hold_cnt_q + 1'b1;
         end
         default: rel = 1'b0;
      endcase

      if (rel) begin
         if (|cand) begin
            state_d    = OWN;
            owner_d    = win;
            gnt_d      = 3'b001 << win;
            rr_ptr_d   = (win == 2'd2) ? 2'd0 : win + 2'd1;
            hold_cnt_d = '0;
         end else begin
            state_d    = IDLE;
            gnt_d      = 3'b000;
            hold_cnt_d = '0;
         end
      end
   end

   // Storage port: combinational pass-through from the owner while it requests.
   always_comb begin
      s_addr  = '0;
      s_wdata = '0;
      s_we    = 1'b0;
      rd_acc  = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (gnt_q[i] && req[i]) begin
            s_addr    = m_addr[i*ADDR_W +: ADDR_W];
            s_wdata   = m_wdata[i*DATA_W +: DATA_W];
            s_we      = m_we[i];
            rd_acc[i] = ~m_we[i];
         end
      end
   end

   // Read-valid delay line: one RD_LAT-deep shift register per port.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rd_pipe_d[i][0] = rd_acc[i];
         for (int j = 1; j < RD_LAT; j++)
            rd_pipe_d[i][j] = rd_pipe_q[i][j-1];
         rvalid[i] = rd_pipe_q[i][RD_LAT-1];
      end
   end

   // State registers; reset drops grants and in-flight read pulses at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= 2'd0;
         gnt_q      <= 3'b000;
         rr_ptr_q   <= 2'd0;
         hold_cnt_q <= '0;
         for (int i = 0; i < 3; i++) rd_pipe_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         hold_cnt_q <= hold_cnt_d;
         for (int i = 0; i < 3; i++) rd_pipe_q[i] <= rd_pipe_d[i];
      end
   end

   assign gnt  = gnt_q;
   assign busy = |gnt_q;

endmodule
